// File: rtl/fetch_pkg.sv
// Shared types, redirect encodings and default parameters for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERROR = 2'd2
    } fetch_state_t;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JAL    = 2'b10;
    localparam logic [1:0] SEL_JALR   = 2'b11;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_IMEM_AW  = 10;
    localparam int          DEF_FQ_DEPTH = 4;
    localparam logic [63:0] DEF_RESET_PC = 64'h0;

    // Low two bits of the effective redirect target; jalr drops bit 0.
    function automatic logic [1:0] redirect_lsbs(input logic [1:0] sel, input logic [1:0] lsbs);
        logic [1:0] r;
        unique case (sel)
            SEL_JALR:            r = {lsbs[1], 1'b0};
            SEL_BRANCH, SEL_JAL: r = lsbs;
            default:             r = lsbs;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int IMEM_AW  = DEF_IMEM_AW,
    parameter int FQ_DEPTH = DEF_FQ_DEPTH
);
    logic                        redirect_valid;
    logic [1:0]                  redirect_sel;
    logic [XLEN-1:0]             redirect_target;
    logic                        imem_req;
    logic [IMEM_AW-1:0]          imem_addr;
    logic [31:0]                 imem_rdata;
    // inst_valid/inst_ready: an entry moves only on a cycle where both are high;
    // while inst_valid waits on inst_ready, inst_data and inst_pc stay fixed.
    logic                        inst_valid;
    logic                        inst_ready;
    logic [31:0]                 inst_data;
    logic [XLEN-1:0]             inst_pc;
    logic [$clog2(FQ_DEPTH):0]   fq_count;
    logic                        misalign_err;

    modport master (
        input  redirect_valid, redirect_sel, redirect_target, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc, fq_count, misalign_err
    );

    modport slave (
        output redirect_valid, redirect_sel, redirect_target, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, fq_count, misalign_err
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instruction} entries with a single-cycle flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    // Empty queue presents zeros so decode never sees stale storage.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, redirect handling and fetch-queue flow control.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              IMEM_AW  = DEF_IMEM_AW,
    parameter int              FQ_DEPTH = DEF_FQ_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    fetch_unit_if.master    bus,
    output fetch_state_t    state_o,
    output logic [XLEN-1:0] fetch_pc_o
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;
    logic            err_q, err_d;

    logic            redir_acc;
    logic            redir_mis;
    logic [XLEN-1:0] redir_pc;
    logic            issue;
    logic            pop;
    logic            push;
    logic            full;
    logic            room;
    logic [CW:0]     occupancy;
    logic [CW-1:0]   count;
    logic            head_valid;
    logic [XLEN+31:0] head;

    assign redir_acc = bus.redirect_valid && (bus.redirect_sel != SEL_NONE);
    assign redir_pc  = {bus.redirect_target[XLEN-1:2],
                        redirect_lsbs(bus.redirect_sel, bus.redirect_target[1:0])};
    assign redir_mis = redir_pc[1];

    // In-flight responses already own a slot, so they count against capacity.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign room      = occupancy < (CW+1)'(FQ_DEPTH);
    assign full      = (count == CW'(FQ_DEPTH));

    // No request in a redirect cycle, so the only response ever squashed is the one arriving now.
    assign issue = !reset && (state_q == ST_FETCH) && !redir_acc && room;
    assign push  = inflight_q && !redir_acc;
    assign pop   = head_valid && bus.inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        err_d      = err_q;
        if (redir_acc) begin
            fetch_pc_d = redir_pc;
            state_d    = redir_mis ? ST_ERROR : ST_FETCH;
            err_d      = redir_mis;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
                    if (full && !inflight_q) state_d = ST_HOLD;
                end
                ST_HOLD:  if (!full) state_d = ST_FETCH;
                ST_ERROR: ;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            err_q      <= err_d;
            if (issue) inflight_pc_q <= fetch_pc_q;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .W     (XLEN + 32)
    ) u_queue (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (redir_acc),
        .push_i      (push),
        .push_data_i ({inflight_pc_q, bus.imem_rdata}),
        .pop_i       (pop),
        .valid_o     (head_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = fetch_pc_q[IMEM_AW+1:2];
    assign bus.inst_valid   = head_valid;
    assign bus.inst_data    = head[31:0];
    assign bus.inst_pc      = head[XLEN+31:32];
    assign bus.fq_count     = count;
    assign bus.misalign_err = err_q;
    assign state_o          = state_q;
    assign fetch_pc_o       = fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a stream model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic         clk;
    logic         reset;
    fetch_state_t dbg_state;
    logic [31:0]  dbg_pc;

    fetch_unit_if #(.XLEN(32), .IMEM_AW(10), .FQ_DEPTH(4)) bus ();

    fetch_unit #(.XLEN(32), .IMEM_AW(10), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .state_o    (dbg_state),
        .fetch_pc_o (dbg_pc)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: word content derived from its address, valid one cycle after the strobe
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {6'h2b, a, 6'h15, a};
    endfunction

    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    // scoreboard state: the stream of PCs expected at decode and on the memory port
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;
    logic [31:0] exp_pc;
    logic [31:0] req_pc;
    logic [31:0] exp_q[$];
    bit          exp_err;
    bit          flush_pending;
    bit          hold_pending;
    logic [31:0] held_pc;
    logic [31:0] held_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc        = 32'h0;
        req_pc        = 32'h0;
        exp_err       = 1'b0;
        flush_pending = 1'b0;
        hold_pending  = 1'b0;
        exp_q.delete();
    endtask

    // Checks the current cycle, then advances the model past the coming clock edge.
    task automatic model_check();
        logic        acc;
        logic        popped;
        logic [31:0] tgt;
        acc = bus.redirect_valid && (bus.redirect_sel != 2'b00);
        tgt = bus.redirect_target;
        if (bus.redirect_sel == 2'b11) tgt[0] = 1'b0;
        popped = bus.inst_valid && bus.inst_ready;

        if (flush_pending) begin
            chk("flush_count", 64'(bus.fq_count), 64'(0));
            chk("flush_valid", 64'(bus.inst_valid), 64'(0));
        end
        if (hold_pending) begin
            chk("hold_valid", 64'(bus.inst_valid), 64'(1));
            chk("hold_pc", 64'(bus.inst_pc), 64'(held_pc));
            chk("hold_data", 64'(bus.inst_data), 64'(held_data));
        end
        chk("misalign", 64'(bus.misalign_err), 64'(exp_err));
        chk("fq_bound", 64'(bus.fq_count <= 4), 64'(1));
        if (exp_err) begin
            chk("err_req", 64'(bus.imem_req), 64'(0));
            chk("err_valid", 64'(bus.inst_valid), 64'(0));
        end
        if (bus.imem_req) begin
            chk("req_addr", 64'(bus.imem_addr), 64'(req_pc[11:2]));
            exp_q.push_back(req_pc);
            req_pc = req_pc + 32'd4;
        end
        if (popped) begin
            chk("pop_pc", 64'(bus.inst_pc), 64'(exp_pc));
            chk("pop_data", 64'(bus.inst_data), 64'(mem_word(exp_pc[11:2])));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end

        hold_pending = bus.inst_valid && !bus.inst_ready && !acc;
        held_pc      = bus.inst_pc;
        held_data    = bus.inst_data;
        if (acc) begin
            exp_pc  = tgt;
            req_pc  = tgt;
            exp_err = tgt[1];
            exp_q.delete();
        end
        flush_pending = acc;
    endtask

    // driver tasks
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_redirect();
        bus.redirect_valid  = 1'b0;
        bus.redirect_sel    = 2'b00;
        bus.redirect_target = 32'h0;
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] tgt);
        bus.redirect_valid  = 1'b1;
        bus.redirect_sel    = sel;
        bus.redirect_target = tgt;
        step();
        idle_redirect();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_req"}, 64'(bus.imem_req), 64'(0));
        chk({tag, "_valid"}, 64'(bus.inst_valid), 64'(0));
        chk({tag, "_count"}, 64'(bus.fq_count), 64'(0));
        chk({tag, "_err"}, 64'(bus.misalign_err), 64'(0));
        chk({tag, "_data"}, 64'(bus.inst_data), 64'(0));
        chk({tag, "_pc"}, 64'(bus.inst_pc), 64'(0));
        chk({tag, "_state"}, 64'(dbg_state), 64'(ST_FETCH));
        chk({tag, "_fpc"}, 64'(dbg_pc), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        #1;
        while (!bus.inst_valid && n < 20) begin
            step();
            #1;
            n++;
        end
        chk(tag, 64'(bus.inst_valid), 64'(1));
    endtask

    initial begin
        reset = 1'b1;
        bus.inst_ready = 1'b0;
        idle_redirect();
        model_reset();

        // Scenario 1: streaming from RESET_PC
        do_reset("s1_rst");
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s1_req", 64'(bus.imem_req), 64'(1));
            chk("s1_addr", 64'(bus.imem_addr), 64'(i));
            if (i >= 2) chk("s1_pc", 64'(bus.inst_pc), 64'((i - 2) * 4));
            step();
        end
        #1;
        chk("s1_pc", 64'(bus.inst_pc), 64'(8));

        // Scenario 2: decode stalled, queue saturates
        bus.inst_ready = 1'b0;
        redirect(SEL_JAL, 32'h0);
        for (int i = 0; i < 8; i++) step();
        #1;
        chk("s2_count", 64'(bus.fq_count), 64'(4));
        chk("s2_req", 64'(bus.imem_req), 64'(0));
        chk("s2_head", 64'(bus.inst_pc), 64'(0));
        chk("s2_state", 64'(dbg_state), 64'(ST_HOLD));

        // Scenario 3: jal redirect with three entries queued
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        #1;
        chk("s3_count3", 64'(bus.fq_count), 64'(3));
        redirect(SEL_JAL, 32'h40);
        #1;
        chk("s3_flush", 64'(bus.fq_count), 64'(0));
        chk("s3_req", 64'(bus.imem_req), 64'(1));
        chk("s3_addr", 64'(bus.imem_addr), 64'(32'h10));
        bus.inst_ready = 1'b1;
        wait_valid("s3_wait");
        chk("s3_pc", 64'(bus.inst_pc), 64'(32'h40));

        // Scenario 4: jalr clears bit 0; misaligned branch parks in ERROR
        redirect(SEL_JALR, 32'h81);
        #1;
        chk("s4_jalr_addr", 64'(bus.imem_addr), 64'(32'h20));
        wait_valid("s4_wait");
        chk("s4_jalr_pc", 64'(bus.inst_pc), 64'(32'h80));
        redirect(SEL_BRANCH, 32'h82);
        #1;
        chk("s4_err", 64'(bus.misalign_err), 64'(1));
        chk("s4_state", 64'(dbg_state), 64'(ST_ERROR));
        for (int i = 0; i < 5; i++) step();
        redirect(SEL_BRANCH, 32'h100);
        #1;
        chk("s4_clear", 64'(bus.misalign_err), 64'(0));
        chk("s4_resume", 64'(bus.imem_addr), 64'(32'h40));
        chk("s4_resume_req", 64'(bus.imem_req), 64'(1));

        // redirect coinciding with a pop, then a sel=00 redirect that must be ignored
        wait_valid("s4b_wait");
        redirect(SEL_JAL, 32'h200);
        #1;
        chk("pop_redir_valid", 64'(bus.inst_valid), 64'(0));
        redirect(SEL_NONE, 32'h300);
        #1;
        chk("sel00_addr", 64'(bus.imem_addr), 64'(32'h81));
        wait_valid("sel00_wait");
        chk("sel00_pc", 64'(bus.inst_pc), 64'(32'h200));

        // Scenario 5: reset while full with a response in flight
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        do_reset("s5_rst");
        #1;
        chk("s5_req", 64'(bus.imem_req), 64'(1));
        chk("s5_addr", 64'(bus.imem_addr), 64'(0));
        bus.inst_ready = 1'b1;
        wait_valid("s5_wait");
        chk("s5_pc", 64'(bus.inst_pc), 64'(0));

        // Scenario 6: PC wraps modulo 2^32
        redirect(SEL_JAL, 32'hFFFF_FFFC);
        #1;
        chk("s6_fpc", 64'(dbg_pc), 64'(32'hFFFF_FFFC));
        chk("s6_addr", 64'(bus.imem_addr), 64'(10'h3FF));
        step();
        #1;
        chk("s6_wrap_fpc", 64'(dbg_pc), 64'(0));
        chk("s6_wrap_addr", 64'(bus.imem_addr), 64'(0));
        wait_valid("s6_wait");
        chk("s6_pc_hi", 64'(bus.inst_pc), 64'(32'hFFFF_FFFC));
        step();
        #1;
        chk("s6_pc_lo", 64'(bus.inst_pc), 64'(0));

        // randomized run against the stream model
        n_deliv = 0;
        for (int c = 0; c < 1500; c++) begin
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            if (c == 700) begin
                do_reset("rnd_rst");
            end else if ($urandom_range(0, 39) == 0) begin
                int r;
                logic [31:0] t;
                r = $urandom_range(0, 7);
                t = 32'($urandom_range(0, 1023)) << 2;
                if (r == 0) t = t | 32'h2;
                else if (r == 1) t = t | 32'h1;
                redirect(2'($urandom_range(0, 3)), t);
            end else begin
                step();
            end
        end
        chk("rnd_progress", 64'(n_deliv > 300), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC and redirect-target width.
REQ-002 The block SHALL have parameter IMEM_AW, default 10, meaning instruction-memory word-address width.
REQ-003 The block SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries (power of two, at least 2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetched PC.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit, meaning the PC redirect is valid this cycle.
REQ-008 The block SHALL have port redirect_sel, input, 2 bits, with encoding 01 branch, 10 jal, 11 jalr; 00 is ignored.
REQ-009 The block SHALL have port redirect_target, input, XLEN bits, meaning the redirect target PC.
REQ-010 The block SHALL have port imem_req, output, 1 bit, meaning instruction-memory read strobe.
REQ-011 The block SHALL have port imem_addr, output, IMEM_AW bits, carrying word address pc[IMEM_AW+1:2].
REQ-012 The block SHALL have port imem_rdata, input, 32 bits, with read data valid exactly one cycle after imem_req.
REQ-013 The block SHALL have port inst_valid, output, 1 bit, meaning the queue head is valid toward decode.
REQ-014 The block SHALL have port inst_ready, input, 1 bit, meaning decode accepts the head.
REQ-015 The block SHALL have port inst_data, output, 32 bits, carrying the head instruction.
REQ-016 The block SHALL have port inst_pc, output, XLEN bits, carrying the head instruction's PC.
REQ-017 The block SHALL have port fq_count, output, $clog2(FQ_DEPTH)+1 bits, carrying the queue occupancy.
REQ-018 The block SHALL have port misalign_err, output, 1 bit, a sticky misaligned-redirect flag.

Function
REQ-019 A queue entry SHALL transfer only on a cycle with inst_valid=1 and inst_ready=1.
REQ-020 inst_data and inst_pc SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-021 imem_req SHALL assert only when fq_count plus in-flight requests is less than FQ_DEPTH, and the state is FETCH.
REQ-022 Each issued request SHALL advance fetch_pc by 4, wrapping modulo 2^XLEN.
REQ-023 Each response SHALL be written to the queue with its request PC one cycle after issue, unless squashed.
REQ-024 Pop and push in the same cycle SHALL leave fq_count unchanged; push into a full queue SHALL NOT occur by construction.
REQ-025 The FSM SHALL have states FETCH, HOLD and ERROR.
REQ-026 In FETCH, the FSM SHALL go to HOLD when the queue is full and no response is in flight.
REQ-027 In HOLD, the FSM SHALL return to FETCH when a slot frees.
REQ-028 A redirect with redirect_sel 11 SHALL use target with bit 0 cleared; sels 01 and 10 SHALL use the target unmodified.
REQ-029 On an accepted redirect, the block SHALL flush the queue (fq_count=0 the next cycle) and squash any in-flight response.
REQ-030 On an accepted redirect, fetch_pc SHALL load the target, and the first new imem_req SHALL issue in the cycle after the redirect.
REQ-031 A redirect with a target where bit 1 is set (after the bit-0 clear) SHALL go to ERROR, set misalign_err and stop issuing requests.
REQ-032 ERROR SHALL be left only by an aligned redirect, which clears misalign_err.
REQ-033 When a redirect coincides with a pop, the redirect SHALL win; the pop completes and inst_valid=0 the next cycle.
REQ-034 redirect_valid with redirect_sel=00 SHALL have no effect.

Reset
REQ-035 While reset=1, the block SHALL hold imem_req=0, inst_valid=0, fq_count=0, misalign_err=0, inst_data=0, inst_pc=0, fetch_pc=RESET_PC and state FETCH.
REQ-036 The first imem_req SHALL issue with imem_addr=RESET_PC[IMEM_AW+1:2] in the first cycle after reset deasserts.
REQ-037 Reset asserted mid-operation SHALL discard queued and in-flight instructions immediately.

Structure
REQ-038 Package fetch_pkg SHALL hold the fetch_state_t enum, the redirect_sel encoding constants and the default parameter values.
REQ-039 The queue SHALL be sub-module fetch_queue, a synchronous FIFO of {pc, instruction} entries with flush input; all other logic resides in fetch_unit.

Verification
REQ-040 Scenario 1: release reset with inst_ready=1 and RESET_PC=0 -> imem_addr is 0,1,2,3 on consecutive cycles, and inst_pc is 0,4,8 in order.
REQ-041 Scenario 2: hold inst_ready=0 -> fq_count saturates at 4, imem_req stays low, and the head stays at pc 0.
REQ-042 Scenario 3: jal redirect to 0x40 with 3 entries queued -> fq_count=0 the next cycle, the next imem_addr is 0x10, and no stale pc is delivered.
REQ-043 Scenario 4: jalr redirect target 0x81 -> fetch resumes at 0x80; a branch redirect to 0x82 -> misalign_err=1, no requests issue until a redirect to 0x100.
REQ-044 Scenario 5: assert reset while in flight and full -> outputs match REQ-035 within the same cycle, and refetch restarts at RESET_PC.
REQ-045 Scenario 6: fetch_pc 0xFFFF_FFFC -> the next PC is 0x0000_0000.
